branch_resolve_ctrl: RTL and testbench

//  D-stage controller that sequences the branch comparator (CMP) in the 5-stage pipeline.
//  - For beq/bne in D: checks operand readiness against E/M/W producers and stalls D/F until ready.
//  - Selects CMP operand forwarding sources, drives CMPOp, and turns CMPOut into the next-PC redirect.
//  - Keeps branch statistics and a stall watchdog.

---
 rtl/branch_resolve_ctrl_pkg.sv | 25 ++
 rtl/branch_resolve_ctrl_if.sv | 32 +++
 rtl/branch_resolve_ctrl_fwd_pick.sv | 28 ++
 rtl/branch_resolve_ctrl.sv | 115 +++++++++++
 tb/tb_branch_resolve_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants and types for the D-stage branch resolution controller.
// Includes the CMP opcodes, the forwarding source codes and the FSM state type.
package branch_resolve_ctrl_pkg;

  localparam logic [7:0] CMP_NONE = 8'h00;
  localparam logic [7:0] CMP_EQ   = 8'h01;
  localparam logic [7:0] CMP_NE   = 8'h02;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam int unsigned WD_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } brc_state_e;

  function automatic logic [7:0] cmp_op_for(input logic br_ne);
    return br_ne ? CMP_NE : CMP_EQ;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Pipeline-side signals of the branch controller: D/E/M/W register info,
// comparator handshake and the stall / redirect controls.
interface branch_resolve_ctrl_if;
  logic       flush;
  logic       d_is_branch;
  logic       d_br_ne;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [4:0] e_wa;
  logic [4:0] m_wa;
  logic [4:0] w_wa;
  logic [1:0] e_tnew;
  logic [1:0] m_tnew;
  logic       cmp_out;
  logic [7:0] cmp_op;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;
  logic       stall;
  logic       npc_br;

  modport master (
    output flush, d_is_branch, d_br_ne, d_rs, d_rt,
           e_wa, m_wa, w_wa, e_tnew, m_tnew, cmp_out,
    input  cmp_op, fwd_sel1, fwd_sel2, stall, npc_br
  );

  modport slave (
    input  flush, d_is_branch, d_br_ne, d_rs, d_rt,
           e_wa, m_wa, w_wa, e_tnew, m_tnew, cmp_out,
    output cmp_op, fwd_sel1, fwd_sel2, stall, npc_br
  );
endinterface

// File: rtl/branch_resolve_ctrl_fwd_pick.sv
// Per-operand hazard detection and CMP forwarding-source selection
// for a branch source register (Tuse = 0).
module branch_resolve_ctrl_fwd_pick
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [4:0] r,
  input  logic [4:0] e_wa,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_wa,
  input  logic [1:0] m_tnew,
  input  logic [4:0] w_wa,
  output logic       haz,
  output logic [1:0] sel
);

  always_comb begin
    haz = (r != '0) &&
          (((r == e_wa) && (e_tnew != '0)) ||
           ((r == m_wa) && (m_tnew != '0)));
    sel = FWD_RF;
    // Youngest ready producer wins; $0 is never forwarded.
    if (r == '0)                             sel = FWD_RF;
    else if ((r == e_wa) && (e_tnew == '0))  sel = FWD_E;
    else if ((r == m_wa) && (m_tnew == '0))  sel = FWD_M;
    else if (r == w_wa)                      sel = FWD_W;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// D-stage branch controller: stalls beq/bne until operands are ready, resolves
// them through the comparator, and keeps taken/not-taken stats plus a stall watchdog.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WD_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_ctrl_if.slave  bus,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      taken_cnt,
  output logic [CNT_W-1:0]      ntaken_cnt
);

  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WD_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  brc_state_e      state, state_nx;
  logic            haz_rs, haz_rt, hazard;
  logic [1:0]      sel_rs, sel_rt;
  logic            stall, resolve;
  logic [WD_W-1:0] stall_run;

  branch_resolve_ctrl_fwd_pick u_pick_rs (
    .r      (bus.d_rs),
    .e_wa   (bus.e_wa),
    .e_tnew (bus.e_tnew),
    .m_wa   (bus.m_wa),
    .m_tnew (bus.m_tnew),
    .w_wa   (bus.w_wa),
    .haz    (haz_rs),
    .sel    (sel_rs)
  );

  branch_resolve_ctrl_fwd_pick u_pick_rt (
    .r      (bus.d_rt),
    .e_wa   (bus.e_wa),
    .e_tnew (bus.e_tnew),
    .m_wa   (bus.m_wa),
    .m_tnew (bus.m_tnew),
    .w_wa   (bus.w_wa),
    .haz    (haz_rt),
    .sel    (sel_rt)
  );

  assign hazard = bus.d_is_branch && !bus.flush && (haz_rs || haz_rt);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    resolve  = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_IDLE: begin
          if (hazard) begin
            stall    = 1'b1;
            state_nx = ST_WAIT;
          end else begin
            resolve = bus.d_is_branch && !bus.flush;
          end
        end
        ST_WAIT: begin
          if (bus.flush) begin
            state_nx = ST_IDLE;
          end else if (hazard) begin
            stall = 1'b1;
          end else begin
            state_nx = ST_IDLE;
            resolve  = bus.d_is_branch;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stall    = stall;
    bus.cmp_op   = resolve ? cmp_op_for(bus.d_br_ne) : CMP_NONE;
    bus.npc_br   = resolve && bus.cmp_out;
    bus.fwd_sel1 = reset ? FWD_RF : sel_rs;
    bus.fwd_sel2 = reset ? FWD_RF : sel_rt;
  end

  // Timeout latches on the edge that ends the WD_LIMIT-th consecutive stall cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_run     <= '0;
      stall_timeout <= 1'b0;
    end else if (stall) begin
      if (stall_run != '1) stall_run <= stall_run + WD_W'(1);
      if (stall_run == WD_LAST) stall_timeout <= 1'b1;
    end else begin
      stall_run <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (resolve) begin
      if (bus.cmp_out) taken_cnt  <= taken_cnt + CNT_ONE;
      else             ntaken_cnt <= ntaken_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a default instance plus a narrow-counter,
// short-watchdog instance driven with identical stimulus.
module tb_branch_resolve_ctrl;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  branch_resolve_ctrl_if b ();
  branch_resolve_ctrl_if bw ();

  logic        to_m, to_w;
  logic [31:0] tk_m, nt_m;
  logic [3:0]  tk_w, nt_w;

  branch_resolve_ctrl dut (
    .clk(clk), .reset(reset), .bus(b),
    .stall_timeout(to_m), .taken_cnt(tk_m), .ntaken_cnt(nt_m)
  );

  branch_resolve_ctrl #(.CNT_W(4), .WD_LIMIT(3)) dut_w (
    .clk(clk), .reset(reset), .bus(bw),
    .stall_timeout(to_w), .taken_cnt(tk_w), .ntaken_cnt(nt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "time limit");
  end

  task automatic drive(input logic br, input logic ne, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ew, input logic [1:0] et, input logic [4:0] mw,
                       input logic [1:0] mt, input logic [4:0] ww, input logic co, input logic fl);
    b.d_is_branch = br;  bw.d_is_branch = br;
    b.d_br_ne = ne;      bw.d_br_ne = ne;
    b.d_rs = rs;         bw.d_rs = rs;
    b.d_rt = rt;         bw.d_rt = rt;
    b.e_wa = ew;         bw.e_wa = ew;
    b.e_tnew = et;       bw.e_tnew = et;
    b.m_wa = mw;         bw.m_wa = mw;
    b.m_tnew = mt;       bw.m_tnew = mt;
    b.w_wa = ww;         bw.w_wa = ww;
    b.cmp_out = co;      bw.cmp_out = co;
    b.flush = fl;        bw.flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    drive(1, 0, 5'd2, 5'd4, 5'd2, 2'd1, 0, 0, 5'd4, 1, 0);
    #1;
    n_cmp++; if (b.stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0h want 0", b.stall); end
    n_cmp++; if (b.npc_br !== 1'b0) begin n_bad++; $display("FAIL rst_npc: got %0h want 0", b.npc_br); end
    n_cmp++; if (b.cmp_op !== 8'h00) begin n_bad++; $display("FAIL rst_cmpop: got %0h want 0", b.cmp_op); end
    n_cmp++; if (b.fwd_sel2 !== 2'd0) begin n_bad++; $display("FAIL rst_sel2: got %0h want 0", b.fwd_sel2); end
    tick();
    n_cmp++; if (tk_m !== 32'd0 || nt_m !== 32'd0) begin n_bad++; $display("FAIL rst_cnt: got %0h/%0h want 0/0", tk_m, nt_m); end
    n_cmp++; if (to_m !== 1'b0 || to_w !== 1'b0) begin n_bad++; $display("FAIL rst_to: got %0h/%0h want 0/0", to_m, to_w); end
    idle();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_beq_taken();
    drive(1, 0, 5'd1, 5'd1, 0, 0, 0, 0, 0, 1, 0);
    #1;
    n_cmp++; if (b.stall !== 1'b0) begin n_bad++; $display("FAIL t1_stall: got %0h want 0", b.stall); end
    n_cmp++; if (b.cmp_op !== 8'h01) begin n_bad++; $display("FAIL t1_cmpop: got %0h want 01", b.cmp_op); end
    n_cmp++; if (b.npc_br !== 1'b1) begin n_bad++; $display("FAIL t1_npc: got %0h want 1", b.npc_br); end
    n_cmp++; if (tk_m !== 32'd0) begin n_bad++; $display("FAIL t1_taken_pre: got %0h want 0", tk_m); end
    tick();
    n_cmp++; if (tk_m !== 32'd1 || nt_m !== 32'd0) begin n_bad++; $display("FAIL t1_cnt: got %0h/%0h want 1/0", tk_m, nt_m); end
    idle();
    #1;
    n_cmp++; if (b.cmp_op !== 8'h00 || b.npc_br !== 1'b0) begin n_bad++; $display("FAIL t1_idle: got %0h/%0h want 0/0", b.cmp_op, b.npc_br); end
    tick();
  endtask

  task automatic test_bne_stall();
    drive(1, 1, 5'd2, 5'd3, 5'd2, 2'd1, 0, 0, 0, 1, 0);
    #1;
    n_cmp++; if (b.stall !== 1'b1) begin n_bad++; $display("FAIL t2_stall: got %0h want 1", b.stall); end
    n_cmp++; if (b.cmp_op !== 8'h00 || b.npc_br !== 1'b0) begin n_bad++; $display("FAIL t2_noresolve: got %0h/%0h want 0/0", b.cmp_op, b.npc_br); end
    n_cmp++; if (b.fwd_sel1 !== 2'd0) begin n_bad++; $display("FAIL t2_sel1_busy: got %0h want 0", b.fwd_sel1); end
    tick();
    n_cmp++; if (tk_m !== 32'd1) begin n_bad++; $display("FAIL t2_cnt_hold: got %0h want 1", tk_m); end
    drive(1, 1, 5'd2, 5'd3, 0, 0, 5'd2, 2'd0, 0, 1, 0);
    #1;
    n_cmp++; if (b.stall !== 1'b0) begin n_bad++; $display("FAIL t2_release: got %0h want 0", b.stall); end
    n_cmp++; if (b.fwd_sel1 !== 2'd2 || b.fwd_sel2 !== 2'd0) begin n_bad++; $display("FAIL t2_sels: got %0h/%0h want 2/0", b.fwd_sel1, b.fwd_sel2); end
    n_cmp++; if (b.cmp_op !== 8'h02 || b.npc_br !== 1'b1) begin n_bad++; $display("FAIL t2_resolve: got %0h/%0h want 02/1", b.cmp_op, b.npc_br); end
    tick();
    n_cmp++; if (tk_m !== 32'd2 || nt_m !== 32'd0) begin n_bad++; $display("FAIL t2_cnt: got %0h/%0h want 2/0", tk_m, nt_m); end
    idle();
    tick();
  endtask

  task automatic test_fwd_select();
    drive(1, 0, 5'd0, 5'd5, 5'd0, 2'd2, 0, 0, 5'd5, 0, 0);
    #1;
    n_cmp++; if (b.stall !== 1'b0) begin n_bad++; $display("FAIL t3_stall: got %0h want 0", b.stall); end
    n_cmp++; if (b.fwd_sel1 !== 2'd0 || b.fwd_sel2 !== 2'd3) begin n_bad++; $display("FAIL t3_sels: got %0h/%0h want 0/3", b.fwd_sel1, b.fwd_sel2); end
    n_cmp++; if (b.cmp_op !== 8'h01 || b.npc_br !== 1'b0) begin n_bad++; $display("FAIL t3_resolve: got %0h/%0h want 01/0", b.cmp_op, b.npc_br); end
    tick();
    n_cmp++; if (tk_m !== 32'd2 || nt_m !== 32'd1) begin n_bad++; $display("FAIL t3_cnt: got %0h/%0h want 2/1", tk_m, nt_m); end
    // same register on both sides, E ready beats ready M and W
    drive(1, 0, 5'd7, 5'd7, 5'd7, 2'd0, 5'd7, 2'd0, 5'd7, 1, 0);
    #1;
    n_cmp++; if (b.fwd_sel1 !== 2'd1 || b.fwd_sel2 !== 2'd1) begin n_bad++; $display("FAIL t3_same: got %0h/%0h want 1/1", b.fwd_sel1, b.fwd_sel2); end
    tick();
    n_cmp++; if (tk_m !== 32'd3) begin n_bad++; $display("FAIL t3_same_cnt: got %0h want 3", tk_m); end
    // rt busy in M stalls even though rs is clean
    drive(1, 0, 5'd1, 5'd8, 0, 0, 5'd8, 2'd1, 0, 1, 0);
    #1;
    n_cmp++; if (b.stall !== 1'b1) begin n_bad++; $display("FAIL t3_mhaz: got %0h want 1", b.stall); end
    idle();
    tick();
    // non-branch with busy registers: inert, but forwarding still reported
    drive(0, 0, 5'd4, 5'd6, 5'd6, 2'd2, 0, 0, 5'd4, 1, 0);
    #1;
    n_cmp++; if (b.stall !== 1'b0 || b.cmp_op !== 8'h00) begin n_bad++; $display("FAIL t3_nonbr: got %0h/%0h want 0/0", b.stall, b.cmp_op); end
    n_cmp++; if (b.fwd_sel1 !== 2'd3) begin n_bad++; $display("FAIL t3_nonbr_sel: got %0h want 3", b.fwd_sel1); end
    tick();
    n_cmp++; if (tk_m !== 32'd3 || nt_m !== 32'd1) begin n_bad++; $display("FAIL t3_nonbr_cnt: got %0h/%0h want 3/1", tk_m, nt_m); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    drive(1, 1, 5'd6, 5'd0, 5'd6, 2'd2, 0, 0, 0, 1, 0);
    #1;
    n_cmp++; if (b.stall !== 1'b1) begin n_bad++; $display("FAIL t5_stall: got %0h want 1", b.stall); end
    tick();
    drive(1, 1, 5'd6, 5'd0, 5'd6, 2'd2, 0, 0, 0, 1, 1);
    #1;
    n_cmp++; if (b.stall !== 1'b0 || b.npc_br !== 1'b0 || b.cmp_op !== 8'h00) begin n_bad++; $display("FAIL t5_flush: got %0h/%0h/%0h want 0/0/0", b.stall, b.npc_br, b.cmp_op); end
    tick();
    n_cmp++; if (tk_m !== 32'd3 || nt_m !== 32'd1) begin n_bad++; $display("FAIL t5_cnt: got %0h/%0h want 3/1", tk_m, nt_m); end
    // flush on a ready branch in IDLE also suppresses resolve
    drive(1, 0, 5'd1, 5'd1, 0, 0, 0, 0, 0, 1, 1);
    #1;
    n_cmp++; if (b.npc_br !== 1'b0 || b.cmp_op !== 8'h00) begin n_bad++; $display("FAIL t5_idleflush: got %0h/%0h want 0/0", b.npc_br, b.cmp_op); end
    tick();
    n_cmp++; if (tk_m !== 32'd3) begin n_bad++; $display("FAIL t5_idleflush_cnt: got %0h want 3", tk_m); end
    idle();
    tick();
  endtask

  task automatic test_watchdog();
    drive(1, 0, 5'd9, 5'd9, 5'd9, 2'd1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 254; i++) tick();
    n_cmp++; if (to_m !== 1'b0) begin n_bad++; $display("FAIL t4_to_254: got %0h want 0", to_m); end
    n_cmp++; if (to_w !== 1'b1) begin n_bad++; $display("FAIL t4_to_small: got %0h want 1", to_w); end
    n_cmp++; if (b.stall !== 1'b1) begin n_bad++; $display("FAIL t4_still_stall: got %0h want 1", b.stall); end
    tick();
    n_cmp++; if (to_m !== 1'b1) begin n_bad++; $display("FAIL t4_to_255: got %0h want 1", to_m); end
    idle();
    tick();
    tick();
    n_cmp++; if (to_m !== 1'b1) begin n_bad++; $display("FAIL t4_sticky: got %0h want 1", to_m); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (to_m !== 1'b0 || to_w !== 1'b0) begin n_bad++; $display("FAIL t4_rst: got %0h/%0h want 0/0", to_m, to_w); end
    n_cmp++; if (tk_m !== 32'd0 || nt_m !== 32'd0) begin n_bad++; $display("FAIL t4_rst_cnt: got %0h/%0h want 0/0", tk_m, nt_m); end
    tick();
  endtask

  task automatic test_back_to_back_wrap();
    drive(1, 0, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if (nt_m !== 32'd15 || nt_w !== 4'hF) begin n_bad++; $display("FAIL t6_pre: got %0h/%0h want f/f", nt_m, nt_w); end
    #1;
    n_cmp++; if (bw.cmp_op !== 8'h01 || bw.npc_br !== 1'b0) begin n_bad++; $display("FAIL t6_resolve: got %0h/%0h want 01/0", bw.cmp_op, bw.npc_br); end
    tick();
    n_cmp++; if (nt_w !== 4'h0) begin n_bad++; $display("FAIL t6_wrap: got %0h want 0", nt_w); end
    n_cmp++; if (nt_m !== 32'd16 || tk_w !== 4'h0) begin n_bad++; $display("FAIL t6_others: got %0h/%0h want 10/0", nt_m, tk_w); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(1, 0, 5'd3, 5'd4, 5'd3, 2'd1, 0, 0, 5'd4, 1, 0);
    tick();
    tick();
    #1;
    n_cmp++; if (b.stall !== 1'b1 || b.fwd_sel2 !== 2'd3) begin n_bad++; $display("FAIL t7_wait: got %0h/%0h want 1/3", b.stall, b.fwd_sel2); end
    reset = 1'b1;
    #1;
    n_cmp++; if (b.stall !== 1'b0 || b.fwd_sel2 !== 2'd0 || b.cmp_op !== 8'h00) begin n_bad++; $display("FAIL t7_rst_out: got %0h/%0h/%0h want 0/0/0", b.stall, b.fwd_sel2, b.cmp_op); end
    tick();
    n_cmp++; if (tk_m !== 32'd0 || nt_m !== 32'd0) begin n_bad++; $display("FAIL t7_rst_cnt: got %0h/%0h want 0/0", tk_m, nt_m); end
    reset = 1'b0;
    drive(1, 0, 5'd3, 5'd4, 5'd3, 2'd0, 0, 0, 5'd4, 1, 0);
    #1;
    n_cmp++; if (b.stall !== 1'b0 || b.fwd_sel1 !== 2'd1 || b.npc_br !== 1'b1) begin n_bad++; $display("FAIL t7_after: got %0h/%0h/%0h want 0/1/1", b.stall, b.fwd_sel1, b.npc_br); end
    tick();
    n_cmp++; if (tk_m !== 32'd1) begin n_bad++; $display("FAIL t7_after_cnt: got %0h want 1", tk_m); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_stall();
    test_fwd_select();
    test_flush();
    test_watchdog();
    test_back_to_back_wrap();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
